aes128_decrypt_iter: RTL

Iterative AES-128 inverse cipher (FIPS-197 InvCipher): the decryption counterpart of the team's AES encryption path. It accepts one 128-bit ciphertext block plus the 1408-bit expanded key schedule produced by `keys_128`, executes one inverse round per clock, and returns the plaintext over a valid/ready handshake. It sits beside the encrypt datapath and shares its key-expansion output.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_inv_round.sv | 47 ++++
 rtl/aes128_decrypt_iter.sv | 116 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: the inverse S-box, GF(2^8) multipliers,
// the FSM state encoding and the round / round-key width constants.
package aes_pkg;

    localparam int AES_NR   = 10;
    localparam int AES_RK_W = 128;
    localparam int AES_KS_W = AES_RK_W * (AES_NR + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_state_e;

    // Inverse S-box, one row of 16 entries per 128-bit chunk; entry 0x00 in the MSBs.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    // Multiply by {02} modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey and (unless last) InvMixColumns. Byte k of a 128-bit state
// sits at [127-8k -: 8] and is row k%4, column k/4.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] ark;
    logic [127:0] mixed;

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
    endfunction

    // Row r rotates right by r: output column c takes the byte from column c-r.
    always_comb begin
        ark = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[127 - 8 * (4 * c + r) -: 8] =
                    inv_sbox(state_in[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8])
                    ^ round_key[127 - 8 * (4 * c + r) -: 8];
            end
        end
    end

    // InvMixColumns applied column by column after the key has been added.
    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32 * c -: 32] = inv_mix_col(ark[127 - 32 * c -: 32]);
        end
    end

    assign state_out = last ? ark : mixed;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, key schedule
// and ciphertext snapshotted at accept, plaintext returned over valid/ready.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends combinationally on ready on either side.
module aes128_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [127:0]               data_in,
    input  logic [AES_RK_W*(NR+1)-1:0] key_sched,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [127:0]               data_out,
    output aes_state_e                 dbg_state_o
);

    localparam int KS_W = AES_RK_W * (NR + 1);

    aes_state_e      fsm_q, fsm_d;
    logic [127:0]    st_q, st_d;
    logic [3:0]      round_q, round_d;
    logic [KS_W-1:0] key_q, key_d;
    logic [127:0]    dout_q, dout_d;
    logic [127:0]    rk_sel;
    logic [127:0]    round_out;

    aes_inv_round u_round (
        .state_in  (st_q),
        .round_key (rk_sel),
        .last      (round_q == 4'd0),
        .state_out (round_out)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Datapath registers: working state, round counter, key snapshot, output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= '0;
            round_q <= '0;
            key_q   <= '0;
            dout_q  <= '0;
        end else begin
            st_q    <= st_d;
            round_q <= round_d;
            key_q   <= key_d;
            dout_q  <= dout_d;
        end
    end

    // Round key i lives at [KS_W-1-128*i -: 128]; the counter picks it.
    always_comb begin
        rk_sel = '0;
        for (int i = 0; i <= NR; i++) begin
            if (round_q == 4'(i)) begin
                rk_sel = key_q[KS_W - 1 - AES_RK_W * i -: AES_RK_W];
            end
        end
    end

    // Next-state logic, datapath updates and handshake outputs.
    always_comb begin
        fsm_d     = fsm_q;
        st_d      = st_q;
        round_d   = round_q;
        key_d     = key_q;
        dout_d    = dout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    key_d   = key_sched;
                    st_d    = data_in ^ key_sched[KS_W - 1 - AES_RK_W * NR -: AES_RK_W];
                    round_d = 4'(NR - 1);
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (round_q != 4'd0) begin
                    st_d    = round_out;
                    round_d = round_q - 4'd1;
                end else begin
                    dout_d = round_out;
                    fsm_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    assign data_out    = dout_q;
    assign dbg_state_o = fsm_q;

endmodule
